// File: rtl/ctrl_pkg.sv
// Shared RV32I decode constants for the controller: opcodes, ALU function codes,
// memory access types and write-back source encodings.
package ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        FS_ADD  = 4'b0000,
        FS_SLL  = 4'b0001,
        FS_SLT  = 4'b0010,
        FS_SLTU = 4'b0011,
        FS_XOR  = 4'b0100,
        FS_SRL  = 4'b0101,
        FS_OR   = 4'b0110,
        FS_AND  = 4'b0111,
        FS_SUB  = 4'b1000,
        FS_SRA  = 4'b1101
    } fs_t;

    // Load codes equal funct3; 000 doubles as "no access" for non-memory ops.
    localparam logic [2:0] MEM_NONE = 3'b000;
    localparam logic [2:0] MEM_SB   = 3'b011;
    localparam logic [2:0] MEM_SH   = 3'b110;
    localparam logic [2:0] MEM_SW   = 3'b111;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    function automatic logic [2:0] store_mem_type(input logic [2:0] funct3);
        case (funct3)
            3'b000:  return MEM_SB;
            3'b001:  return MEM_SH;
            3'b010:  return MEM_SW;
            default: return MEM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_imm_gen.sv
// Immediate extraction for RV32I: I/S/B/U/J formats, sign-extended to size.
module ctrl_imm_gen #(
    parameter int size = 32
) (
    input  logic [31:7]     instr,
    output logic [size-1:0] imm_i,
    output logic [size-1:0] imm_s,
    output logic [size-1:0] imm_b,
    output logic [size-1:0] imm_u,
    output logic [size-1:0] imm_j
);
    logic [31:0] raw_i, raw_s, raw_b, raw_u, raw_j;

    assign raw_i = {{20{instr[31]}}, instr[31:20]};
    assign raw_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign raw_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign raw_u = {instr[31:12], 12'b0};
    assign raw_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign imm_i = size'($signed(raw_i));
    assign imm_s = size'($signed(raw_s));
    assign imm_b = size'($signed(raw_b));
    assign imm_u = size'($signed(raw_u));
    assign imm_j = size'($signed(raw_j));

endmodule

// File: rtl/controller.sv
// Single-cycle RV32I control unit: PC register plus combinational decode.
// Define CTRL_ILLEGAL_HALT_EN to halt on unknown opcodes instead of treating them as NOPs.
module controller
    import ctrl_pkg::*;
#(
    parameter int size = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              instruction,
    input  logic [size-1:0]          IMM_rs,
    input  logic                     Z,
    input  logic                     N,
    output logic [size-1:0]          PC_Addr,
    output logic [size-1:0]          PC_Save,
    output logic [size-1:0]          IMM_out,
    output logic [2:0]               Mem_type_sel,
    output logic [$clog2(size)-1:0]  A_select,
    output logic [$clog2(size)-1:0]  B_select,
    output logic [$clog2(size)-1:0]  D_addr,
    output logic                     we,
    output logic                     MR,
    output logic                     MD,
    output logic                     MB,
    output logic [3:0]               FS
);
    localparam int SEL_W = $clog2(size);

    logic [size-1:0] pc, pc_next, pc_plus4;
    logic [size-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            f7b5;
    logic [SEL_W-1:0] a_sel;
    logic [size-1:0] imm_o;
    logic [3:0]      fs;
    logic [2:0]      mem;
    logic [1:0]      wb;
    logic            mb, we_c, taken;
`ifdef CTRL_ILLEGAL_HALT_EN
    logic            illegal, halted;
`endif

    assign opcode   = instruction[6:0];
    assign funct3   = instruction[14:12];
    assign f7b5     = instruction[30];
    assign pc_plus4 = pc + size'(4);

    ctrl_imm_gen #(.size(size)) u_imm_gen (
        .instr (instruction[31:7]),
        .imm_i (imm_i),
        .imm_s (imm_s),
        .imm_b (imm_b),
        .imm_u (imm_u),
        .imm_j (imm_j)
    );

    always_comb begin
        a_sel   = SEL_W'(instruction[19:15]);
        imm_o   = '0;
        fs      = FS_ADD;
        mem     = MEM_NONE;
        wb      = WB_ALU;
        mb      = 1'b0;
        we_c    = 1'b0;
        taken   = 1'b0;
        pc_next = pc_plus4;
`ifdef CTRL_ILLEGAL_HALT_EN
        illegal = 1'b0;
`endif
        case (opcode)
            OPC_LUI: begin
                a_sel = '0;
                imm_o = imm_u;
                mb    = 1'b1;
                we_c  = 1'b1;
            end
            OPC_AUIPC: begin
                a_sel = '0;
                imm_o = pc + imm_u;
                mb    = 1'b1;
                we_c  = 1'b1;
            end
            OPC_JAL: begin
                a_sel   = '0;
                imm_o   = imm_j;
                wb      = WB_PC;
                we_c    = 1'b1;
                pc_next = pc + imm_j;
            end
            OPC_JALR: begin
                imm_o   = imm_i;
                mb      = 1'b1;
                wb      = WB_PC;
                we_c    = 1'b1;
                pc_next = {IMM_rs[size-1:1], 1'b0};
            end
            OPC_BRANCH: begin
                imm_o = imm_b;
                // Unsigned compares use SLTU, so "less than" shows up as a nonzero result.
                case (funct3)
                    3'b000:  begin fs = FS_SUB;  taken = Z;  end
                    3'b001:  begin fs = FS_SUB;  taken = !Z; end
                    3'b100:  begin fs = FS_SUB;  taken = N;  end
                    3'b101:  begin fs = FS_SUB;  taken = !N; end
                    3'b110:  begin fs = FS_SLTU; taken = !Z; end
                    3'b111:  begin fs = FS_SLTU; taken = Z;  end
                    default: taken = 1'b0;
                endcase
                if (taken)
                    pc_next = pc + imm_b;
            end
            OPC_LOAD: begin
                imm_o = imm_i;
                mb    = 1'b1;
                wb    = WB_MEM;
                we_c  = 1'b1;
                mem   = funct3;
            end
            OPC_STORE: begin
                imm_o = imm_s;
                mb    = 1'b1;
                mem   = store_mem_type(funct3);
            end
            OPC_OPIMM: begin
                imm_o = imm_i;
                mb    = 1'b1;
                we_c  = 1'b1;
                fs    = (funct3 == 3'b101 && f7b5) ? FS_SRA : {1'b0, funct3};
            end
            OPC_OP: begin
                fs   = {f7b5, funct3};
                we_c = 1'b1;
            end
            default: begin
`ifdef CTRL_ILLEGAL_HALT_EN
                illegal = 1'b1;
`endif
            end
        endcase
`ifdef CTRL_ILLEGAL_HALT_EN
        if (illegal || halted) begin
            we_c    = 1'b0;
            mem     = MEM_NONE;
            pc_next = pc;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc <= '0;
        else
            pc <= pc_next;
    end

`ifdef CTRL_ILLEGAL_HALT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            halted <= 1'b0;
        else if (illegal)
            halted <= 1'b1;
    end
`endif

    assign PC_Addr      = {2'b00, pc[size-1:2]};
    assign PC_Save      = pc_plus4;
    assign IMM_out      = imm_o;
    assign Mem_type_sel = mem;
    assign A_select     = a_sel;
    assign B_select     = SEL_W'(instruction[24:20]);
    assign D_addr       = SEL_W'(instruction[11:7]);
    assign we           = we_c;
    assign MR           = wb[1];
    assign MD           = wb[0];
    assign MB           = mb;
    assign FS           = fs;

endmodule

// File: tb/tb_controller.sv
// Directed bench for controller: hand-computed vectors walked through one program trace.
module tb_controller;
    logic        dummy_clk;
    logic        reset;
    logic [31:0] instruction;
    logic [31:0] IMM_rs;
    logic        Z, N;
    logic [31:0] PC_Addr, PC_Save, IMM_out;
    logic [2:0]  Mem_type_sel;
    logic [4:0]  A_select, B_select, D_addr;
    logic        we, MR, MD, MB;
    logic [3:0]  FS;

    int tests = 0;
    int fails = 0;

    controller #(.size(32)) dut (
        .clk          (dummy_clk),
        .reset        (reset),
        .instruction  (instruction),
        .IMM_rs       (IMM_rs),
        .Z            (Z),
        .N            (N),
        .PC_Addr      (PC_Addr),
        .PC_Save      (PC_Save),
        .IMM_out      (IMM_out),
        .Mem_type_sel (Mem_type_sel),
        .A_select     (A_select),
        .B_select     (B_select),
        .D_addr       (D_addr),
        .we           (we),
        .MR           (MR),
        .MD           (MD),
        .MB           (MB),
        .FS           (FS)
    );

    initial dummy_clk = 1'b0;
    always #5 dummy_clk = ~dummy_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge dummy_clk);
        #1;
    endtask

    initial begin
        logic [31:0] frozen;
        reset = 1'b1; instruction = 32'h0; IMM_rs = 32'h0; Z = 1'b0; N = 1'b0;
        #2;
        chk("rst_pc_addr", PC_Addr, 0);
        chk("rst_pc_save", PC_Save, 4);
        tick();
        chk("rst_hold", PC_Addr, 0);

        // addi x1,x0,5 at pc 0
        reset = 1'b0; instruction = 32'h00500093;
        #1;
        chk("addi_asel", 32'(A_select), 0);
        chk("addi_daddr", 32'(D_addr), 1);
        chk("addi_imm", IMM_out, 5);
        chk("addi_mb", 32'(MB), 1);
        chk("addi_fs", 32'(FS), 0);
        chk("addi_we", 32'(we), 1);
        chk("addi_wb", 32'({MR, MD}), 0);
        chk("addi_mem", 32'(Mem_type_sel), 0);
        tick();
        chk("addi_next", PC_Addr, 1);

        // beq x0,x0,8 at pc 4, not taken
        instruction = 32'h00000463; Z = 1'b0;
        #1;
        chk("beq_fs", 32'(FS), 32'b1000);
        chk("beq_mb", 32'(MB), 0);
        chk("beq_we", 32'(we), 0);
        chk("beq_imm", IMM_out, 8);
        tick();
        chk("beq_nt_next", PC_Addr, 2);

        // jalr x1,0(x1) at pc 8, target 100
        instruction = 32'h000080E7; IMM_rs = 32'd100;
        #1;
        chk("jalr_save", PC_Save, 12);
        chk("jalr_wb", 32'({MR, MD}), 32'b10);
        chk("jalr_we", 32'(we), 1);
        chk("jalr_daddr", 32'(D_addr), 1);
        chk("jalr_mb", 32'(MB), 1);
        tick();
        chk("jalr_next", PC_Addr, 25);

        // lw x2,4(x1) at pc 100
        instruction = 32'h0040A103;
        #1;
        chk("lw_md", 32'(MD), 1);
        chk("lw_mr", 32'(MR), 0);
        chk("lw_mem", 32'(Mem_type_sel), 32'b010);
        chk("lw_imm", IMM_out, 4);
        chk("lw_asel", 32'(A_select), 1);
        chk("lw_daddr", 32'(D_addr), 2);
        chk("lw_we", 32'(we), 1);
        tick();

        // sw x2,8(x1) at pc 104
        instruction = 32'h0020A423;
        #1;
        chk("sw_mem", 32'(Mem_type_sel), 32'b111);
        chk("sw_we", 32'(we), 0);
        chk("sw_bsel", 32'(B_select), 2);
        chk("sw_imm", IMM_out, 8);
        chk("sw_mb", 32'(MB), 1);
        tick();
        chk("sw_next", PC_Addr, 27);

        // bltu x1,x2,16 at pc 108, taken on !Z
        instruction = 32'h0020E863; Z = 1'b0;
        #1;
        chk("bltu_fs", 32'(FS), 32'b0011);
        tick();
        chk("bltu_next", PC_Addr, 31);

        // jal x1,-8 at pc 124
        instruction = 32'hFF9FF0EF;
        #1;
        chk("jal_imm", IMM_out, 32'hFFFF_FFF8);
        chk("jal_save", PC_Save, 128);
        chk("jal_asel", 32'(A_select), 0);
        chk("jal_wb", 32'({MR, MD}), 32'b10);
        tick();
        chk("jal_next", PC_Addr, 29);

        // auipc x3,1 at pc 116
        instruction = 32'h00001197;
        #1;
        chk("auipc_imm", IMM_out, 32'h0000_1074);
        chk("auipc_asel", 32'(A_select), 0);
        chk("auipc_we", 32'(we), 1);
        tick();

        // srai x5,x6,3 at pc 120
        instruction = 32'h40335293;
        #1;
        chk("srai_fs", 32'(FS), 32'b1101);
        chk("srai_mb", 32'(MB), 1);
        tick();

        // sub x1,x2,x3 at pc 124
        instruction = 32'h403100B3;
        #1;
        chk("sub_fs", 32'(FS), 32'b1000);
        chk("sub_mb", 32'(MB), 0);
        chk("sub_sel", 32'({A_select, B_select}), 32'({5'd2, 5'd3}));
        tick();
        chk("sub_next", PC_Addr, 32);

        // unknown opcode at pc 128
        instruction = 32'hFFFFFFFF;
        #1;
        chk("ill_we", 32'(we), 0);
        chk("ill_mem", 32'(Mem_type_sel), 0);
        frozen = PC_Addr;
        tick(); tick(); tick();
`ifdef CTRL_ILLEGAL_HALT_EN
        chk("ill_pc", PC_Addr, 32);
        instruction = 32'h00500093;
        #1;
        chk("halt_we", 32'(we), 0);
        tick();
        chk("halt_pc", PC_Addr, 32);
`else
        chk("ill_pc", PC_Addr, 35);
        instruction = 32'h00500093;
        #1;
        chk("nop_we", 32'(we), 1);
        tick();
        chk("nop_pc", PC_Addr, 36);
`endif
        chk("ill_start", frozen, 32);

        // reset mid-run, then beq taken from pc 4
        reset = 1'b1;
        #1;
        chk("rst2_pc", PC_Addr, 0);
        chk("rst2_save", PC_Save, 4);
        reset = 1'b0; instruction = 32'h00500093;
        tick();
        chk("rst2_next", PC_Addr, 1);
        instruction = 32'h00000463; Z = 1'b1;
        #1;
        chk("rst2_we", 32'(we), 0);
        tick();
        chk("beq_t_next", PC_Addr, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
